temp_stats: RTL and testbench



---
 rtl/temp_pkg.sv | 16 +
 rtl/temp_avg_window.sv | 56 +++++
 rtl/temp_stats.sv | 105 ++++++++++
 tb/tb_temp_stats.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/temp_pkg.sv
// Shared types and constants for the temperature statistics path.
package temp_pkg;

    localparam int TEMP_W = 8;

    typedef logic [TEMP_W-1:0] temp_t;

    localparam temp_t TEMP_ZERO = '0;

    // EMPTY means the next accepted sample restarts the window and min/max.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_RUN   = 1'b1
    } stats_state_t;

endpackage

// File: rtl/temp_avg_window.sv
// Circular sample window with running sum; avg is the combinational average
// including the sample presented this cycle (registered by the parent).
module temp_avg_window
    import temp_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  logic  init,
    input  temp_t din,
    output temp_t avg
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = TEMP_W + AVG_LOG2;

    temp_t                r_buf [DEPTH];
    logic [AVG_LOG2-1:0]  r_ptr;
    logic [SUM_W-1:0]     r_sum;
    logic [SUM_W-1:0]     w_sum_next;
    logic [SUM_W-1:0]     w_din_ext;
    logic [SUM_W-1:0]     w_old_ext;

    assign w_din_ext = {{AVG_LOG2{1'b0}}, din};
    assign w_old_ext = {{AVG_LOG2{1'b0}}, r_buf[r_ptr]};

    // The intermediate may wrap, but the true result always fits in SUM_W bits.
    assign w_sum_next = init ? {din, {AVG_LOG2{1'b0}}}
                             : r_sum - w_old_ext + w_din_ext;

    assign avg = w_sum_next[SUM_W-1:AVG_LOG2];

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the window is only 2..16 entries, so it is cleared in reset
            // rather than left undefined like a large RAM would be.
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= TEMP_ZERO;
            r_ptr <= '0;
            r_sum <= '0;
        end else if (push) begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge values of the others, regardless of statement order.
            if (init) begin
                for (int i = 0; i < DEPTH; i++) r_buf[i] <= din;
                r_ptr <= '0;
            end else begin
                r_buf[r_ptr] <= din;
                r_ptr        <= r_ptr + 1'b1;
            end
            r_sum <= w_sum_next;
        end
    end

endmodule

// File: rtl/temp_stats.sv
// Windowed average plus running min/max of temperature samples.
// Optional alarm outputs are built when TEMP_STATS_ALARM_EN is defined.
module temp_stats
    import temp_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic  CLK100MHZ,
    input  logic  reset,
    input  logic  sample_valid,
    input  temp_t sample_temp,
    input  logic  clear_stats,
    input  temp_t set_temp,
    output temp_t ave_temp,
    output temp_t min_temp,
    output temp_t max_temp,
    output logic  stats_valid
`ifdef TEMP_STATS_ALARM_EN
   ,output logic  alarm_high,
    output logic  alarm_low
`endif
);

    stats_state_t r_state, w_state_next;
    logic         w_first;
    temp_t        w_avg;
    temp_t        w_ave_next, w_min_next, w_max_next;
    logic         w_valid_next;

    // A clear in the same cycle as a sample makes that sample the first one.
    assign w_first = clear_stats || (r_state == ST_EMPTY);

    temp_avg_window #(.AVG_LOG2(AVG_LOG2)) u_window (
        .clk   (CLK100MHZ),
        .reset (reset),
        .push  (sample_valid),
        .init  (w_first),
        .din   (sample_temp),
        .avg   (w_avg)
    );

    always_ff @(posedge CLK100MHZ) begin
        if (reset) r_state <= ST_EMPTY;
        else       r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        w_state_next = r_state;
        w_ave_next   = ave_temp;
        w_min_next   = min_temp;
        w_max_next   = max_temp;
        w_valid_next = stats_valid;
        if (sample_valid) begin
            w_state_next = ST_RUN;
            w_ave_next   = w_avg;
            w_valid_next = 1'b1;
            if (w_first) begin
                w_min_next = sample_temp;
                w_max_next = sample_temp;
            end else begin
                if (sample_temp < min_temp) w_min_next = sample_temp;
                if (sample_temp > max_temp) w_max_next = sample_temp;
            end
        end else if (clear_stats) begin
            w_state_next = ST_EMPTY;
            w_ave_next   = TEMP_ZERO;
            w_min_next   = TEMP_ZERO;
            w_max_next   = TEMP_ZERO;
            w_valid_next = 1'b0;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            ave_temp    <= TEMP_ZERO;
            min_temp    <= TEMP_ZERO;
            max_temp    <= TEMP_ZERO;
            stats_valid <= 1'b0;
        end else begin
            ave_temp    <= w_ave_next;
            min_temp    <= w_min_next;
            max_temp    <= w_max_next;
            stats_valid <= w_valid_next;
        end
    end

`ifdef TEMP_STATS_ALARM_EN
    // Compared against the new average so alarms move on the same edge.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            alarm_high <= 1'b0;
            alarm_low  <= 1'b0;
        end else begin
            alarm_high <= w_valid_next && (w_ave_next > set_temp);
            alarm_low  <= w_valid_next && (w_ave_next < set_temp);
        end
    end
`else
    logic w_unused_set_temp;
    assign w_unused_set_temp = ^set_temp;
`endif

endmodule

// File: tb/tb_temp_stats.sv
// Randomized self-checking bench for temp_stats against a queue-based model.
// Alarm checks are included when TEMP_STATS_ALARM_EN is defined.
module tb_temp_stats;
    import temp_pkg::*;

    localparam int AVG_LOG2 = 2;
    localparam int N        = 1 << AVG_LOG2;

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    logic  sample_valid = 1'b0;
    temp_t sample_temp = '0;
    logic  clear_stats = 1'b0;
    temp_t set_temp = '0;
    temp_t ave_temp, min_temp, max_temp;
    logic  stats_valid;
`ifdef TEMP_STATS_ALARM_EN
    logic  alarm_high, alarm_low;
`endif

    always #5 clk = ~clk;

    temp_stats #(.AVG_LOG2(AVG_LOG2)) dut (
        .CLK100MHZ    (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_temp  (sample_temp),
        .clear_stats  (clear_stats),
        .set_temp     (set_temp),
        .ave_temp     (ave_temp),
        .min_temp     (min_temp),
        .max_temp     (max_temp),
        .stats_valid  (stats_valid)
`ifdef TEMP_STATS_ALARM_EN
       ,.alarm_high   (alarm_high),
        .alarm_low    (alarm_low)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the window is the list of the last N samples.
    int q[$];
    int m_ave = 0, m_min = 0, m_max = 0;
    bit m_valid = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit sv, input int st, input bit clr, input bit rst);
        int sum;
        if (rst || (clr && !sv)) begin
            q.delete();
            m_ave = 0; m_min = 0; m_max = 0; m_valid = 0;
        end else if (sv) begin
            if (clr || !m_valid) begin
                q.delete();
                for (int i = 0; i < N; i++) q.push_back(st);
                m_min = st;
                m_max = st;
            end else begin
                void'(q.pop_front());
                q.push_back(st);
                if (st < m_min) m_min = st;
                if (st > m_max) m_max = st;
            end
            sum = 0;
            foreach (q[i]) sum += q[i];
            m_ave   = sum / N;
            m_valid = 1;
        end
    endtask

    task automatic compare();
        check("ave_temp", int'(ave_temp), m_ave);
        check("min_temp", int'(min_temp), m_min);
        check("max_temp", int'(max_temp), m_max);
        check("stats_valid", int'(stats_valid), int'(m_valid));
`ifdef TEMP_STATS_ALARM_EN
        check("alarm_high", int'(alarm_high), int'(m_valid && (m_ave > int'(set_temp))));
        check("alarm_low",  int'(alarm_low),  int'(m_valid && (m_ave < int'(set_temp))));
`endif
    endtask

    task automatic step(input bit sv, input int st, input bit clr, input bit rst);
        @(negedge clk);
        sample_valid = sv;
        sample_temp  = temp_t'(st);
        clear_stats  = clr;
        reset        = rst;
        @(posedge clk);
        #1;
        model_step(sv, st, clr, rst);
        compare();
    endtask

    initial begin
        int exp_ave[4];
        int exp_max[4];
        int ramp[4];

        // Reset for three cycles, then idle with no samples.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        check("reset_ave", int'(ave_temp), 0);
        check("reset_valid", int'(stats_valid), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        check("idle_max", int'(max_temp), 0);

        // First sample fills the window.
        step(1, 70, 0, 0);
        check("first_ave", int'(ave_temp), 70);
        check("first_min", int'(min_temp), 70);
        check("first_valid", int'(stats_valid), 1);

        ramp    = '{74, 78, 82, 90};
        exp_ave = '{71, 73, 76, 81};
        for (int i = 0; i < 4; i++) begin
            step(1, ramp[i], 0, 0);
            check("ramp_ave", int'(ave_temp), exp_ave[i]);
            check("ramp_max", int'(max_temp), ramp[i]);
            check("ramp_min", int'(min_temp), 70);
        end
        step(0, 0, 0, 0);
        check("hold_ave", int'(ave_temp), 81);

        // Full-scale samples must not overflow the running sum.
        step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 255, 0, 0);
        check("full_ave", int'(ave_temp), 255);
        exp_ave = '{191, 127, 63, 0};
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0);
            check("drain_ave", int'(ave_temp), exp_ave[i]);
        end
        check("drain_min", int'(min_temp), 0);
        check("drain_max", int'(max_temp), 255);

        // Clear together with a sample restarts on that sample.
        step(1, 60, 1, 0);
        check("clrsmp_ave", int'(ave_temp), 60);
        check("clrsmp_max", int'(max_temp), 60);
        check("clrsmp_valid", int'(stats_valid), 1);
        step(0, 0, 1, 0);
        check("clear_min", int'(min_temp), 0);
        check("clear_valid", int'(stats_valid), 0);

`ifdef TEMP_STATS_ALARM_EN
        set_temp = 8'd75;
        step(1, 70, 0, 0);
        check("alm_low_first", int'(alarm_low), 1);
        check("alm_high_first", int'(alarm_high), 0);
        for (int i = 0; i < 3; i++) step(1, 82, 0, 0);
        check("alm_ave79", int'(ave_temp), 79);
        check("alm_high_79", int'(alarm_high), 1);
        check("alm_low_79", int'(alarm_low), 0);
        step(0, 0, 0, 1);
        check("alm_rst_high", int'(alarm_high), 0);
        check("alm_rst_low", int'(alarm_low), 0);
`endif

        // Mid-run reset.
        step(1, 100, 0, 0);
        step(1, 40, 0, 0);
        step(0, 0, 0, 1);
        check("midrst_max", int'(max_temp), 0);

        // Randomized traffic with occasional clears, resets and extreme values.
        exp_max = '{0, 255, 1, 254};
        for (int i = 0; i < 600; i++) begin
            int  st;
            bit  sv, clr, rst;
            sv  = ($urandom_range(0, 99) < 60);
            clr = ($urandom_range(0, 99) < 5);
            rst = ($urandom_range(0, 199) < 3);
            if ($urandom_range(0, 9) == 0) st = exp_max[$urandom_range(0, 3)];
            else                           st = $urandom_range(0, 255);
            if ($urandom_range(0, 49) == 0) set_temp = temp_t'($urandom_range(0, 255));
            step(sv, st, clr, rst);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
